// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round controller: state-mux select
// encodings, FSM state type, round count and the key-schedule RCON table.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    // Select for the 128-bit 8:1 state mux in front of the state/key registers.
    typedef enum logic [2:0] {
        SEL_INIT_ENC  = 3'd0,
        SEL_ROUND_ENC = 3'd1,
        SEL_FINAL_ENC = 3'd2,
        SEL_HOLD      = 3'd3,
        SEL_INIT_DEC  = 3'd4,
        SEL_ROUND_DEC = 3'd5,
        SEL_FINAL_DEC = 3'd6,
        SEL_ZERO      = 3'd7
    } mux_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4,
        ST_CLEAR = 3'd5
    } state_e;

    // RCON indexed by key-schedule step; steps 0 and 11..15 have no constant.
    localparam logic [7:0] RCON_TABLE [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1B, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake bundle between the block source/sink and the round controller.
// The mode signal exists only when AES_DECRYPT_EN is defined.
interface aes_round_ctrl_if;

    logic in_valid;
    logic in_ready;
    logic abort;
    logic out_valid;
    logic out_ready;
`ifdef AES_DECRYPT_EN
    logic mode;      // 0 = encrypt, 1 = decrypt
`endif

    // Side that presents blocks, cancels and consumes results.
    modport master (
`ifdef AES_DECRYPT_EN
        output mode,
`endif
        output in_valid, abort, out_ready,
        input  in_ready, out_valid
    );

    // Controller side.
    modport slave (
`ifdef AES_DECRYPT_EN
        input  mode,
`endif
        input  in_valid, abort, out_ready,
        output in_ready, out_valid
    );

endinterface

// File: rtl/aes_rcon_lut.sv
// Maps a 4-bit key-schedule step index to its 8-bit AES round constant.
module aes_rcon_lut
    import aes_pkg::*;
(
    input  logic [3:0] idx_i,
    output logic [7:0] rcon_o
);

    assign rcon_o = RCON_TABLE[idx_i];

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: steps the state/key datapath through
// INIT, nine ROUND cycles and FINAL, then holds the result in DONE until
// consumed. abort cancels through a one-cycle CLEAR that zeroes the datapath.
// Decrypt sequencing (descending rounds, selects 4..6) and the mode input
// are built only when AES_DECRYPT_EN is defined; the default is encrypt-only.
module aes_round_ctrl
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    aes_round_ctrl_if.slave        ctrl,
    output logic [2:0]             mux_sel_o,
    output logic                   load_en_o,
    output logic [3:0]             round_o,
    output logic [7:0]             rcon_o,
    output logic                   busy_o
);

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       dec_mode;
    logic       start_dec;
    logic       accept;
    logic       last_round;

    mux_sel_e   mux_sel;
    logic       rcon_en;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] rcon_idx;
    logic [7:0] rcon_lut;

    // abort has priority over a new block presented in IDLE.
    assign accept = (state_q == ST_IDLE) && ctrl.in_valid && !ctrl.abort;

`ifdef AES_DECRYPT_EN
    logic dec_q;

    assign start_dec = ctrl.mode;

    // Direction is sampled once at acceptance and held for the whole block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b0;
        end else if (accept) begin
            dec_q <= ctrl.mode;
        end
    end

    assign dec_mode = dec_q;
`else
    assign start_dec = 1'b0;
    assign dec_mode  = 1'b0;
`endif

    // Last ROUND cycle: round 9 when encrypting, round 1 when decrypting.
    assign last_round = dec_mode ? (round_q == 4'd1)
                                 : (round_q == 4'(NUM_ROUNDS - 1));

    // State and round-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            round_q <= 4'd0;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // update from the same pre-edge values regardless of statement order.
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // Next state and next round index.
    always_comb begin
        // NOTE: defaults first so every path assigns every target and no
        // latch is inferred when a case arm leaves a signal unmentioned.
        state_d = state_q;
        round_d = round_q;
        unique case (state_q)
            ST_IDLE: begin
                round_d = 4'd0;
                if (accept) begin
                    state_d = ST_INIT;
                    round_d = start_dec ? 4'(NUM_ROUNDS) : 4'd0;
                end
            end
            ST_INIT: begin
                round_d = dec_mode ? round_q - 4'd1 : round_q + 4'd1;
                state_d = ctrl.abort ? ST_CLEAR : ST_ROUND;
            end
            ST_ROUND: begin
                round_d = dec_mode ? round_q - 4'd1 : round_q + 4'd1;
                if (ctrl.abort) begin
                    state_d = ST_CLEAR;
                end else if (last_round) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                state_d = ctrl.abort ? ST_CLEAR : ST_DONE;
            end
            ST_DONE: begin
                if (ctrl.abort) begin
                    state_d = ST_CLEAR;
                end else if (ctrl.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath controls decoded from registered state only.
    always_comb begin
        mux_sel   = SEL_HOLD;
        load_en_o = 1'b0;
        round_o   = 4'd0;
        rcon_en   = 1'b0;
        busy_o    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_INIT: begin
                mux_sel   = dec_mode ? SEL_INIT_DEC : SEL_INIT_ENC;
                load_en_o = 1'b1;
                round_o   = round_q;
                rcon_en   = 1'b1;
                busy_o    = 1'b1;
            end
            ST_ROUND: begin
                mux_sel   = dec_mode ? SEL_ROUND_DEC : SEL_ROUND_ENC;
                load_en_o = 1'b1;
                round_o   = round_q;
                rcon_en   = 1'b1;
                busy_o    = 1'b1;
            end
            ST_FINAL: begin
                mux_sel   = dec_mode ? SEL_FINAL_DEC : SEL_FINAL_ENC;
                load_en_o = 1'b1;
                round_o   = round_q;
                rcon_en   = 1'b1;
                busy_o    = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
            end
            ST_CLEAR: begin
                mux_sel   = SEL_ZERO;
                load_en_o = 1'b1;
                busy_o    = 1'b1;
            end
            default: begin
                mux_sel = SEL_HOLD;
            end
        endcase
    end

    // Decryption walks the key schedule backwards, so it needs the next step's constant.
    assign rcon_idx = dec_mode ? round_q + 4'd1 : round_q;

    aes_rcon_lut u_rcon_lut (
        .idx_i  (rcon_idx),
        .rcon_o (rcon_lut)
    );

    assign rcon_o         = rcon_en ? rcon_lut : 8'h00;
    assign mux_sel_o      = mux_sel;
    assign ctrl.in_ready  = in_ready;
    assign ctrl.out_valid = out_valid;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have no parameters; round count is fixed at 10 (AES-128).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  block and key are presented to the datapath.
REQ-005 in_ready  out  1  controller can accept a block; equals (state==IDLE).
REQ-006 mode  in  1  0=encrypt, 1=decrypt; port exists only under AES_DECRYPT_EN.
REQ-007 abort  in  1  synchronous cancel of the current operation.
REQ-008 out_valid  out  1  result is held in the state register.
REQ-009 out_ready  in  1  consumer accepts the result.
REQ-010 mux_sel  out  3  select for the 128-bit 8:1 state mux.
REQ-011 load_en  out  1  state/key registers capture the mux output this cycle.
REQ-012 round  out  4  round index of the key in use.
REQ-013 rcon  out  8  round constant for the key schedule.
REQ-014 busy  out  1  high in INIT, ROUND, FINAL and CLEAR.

Function
REQ-015 mux_sel encoding SHALL be: 0 INIT_ENC, 1 ROUND_ENC, 2 FINAL_ENC, 3 HOLD, 4 INIT_DEC, 5 ROUND_DEC, 6 FINAL_DEC, 7 ZERO.
REQ-016 The FSM states SHALL be IDLE, INIT, ROUND, FINAL, DONE and CLEAR.
REQ-017 In IDLE: mux_sel=HOLD, load_en=0, round=0; in_valid&in_ready moves the FSM to INIT.
REQ-018 In INIT (1 cycle): load_en=1; mux_sel=INIT_ENC with round=0 (enc), or INIT_DEC with round=10 (dec).
REQ-019 In ROUND (9 cycles): load_en=1; mux_sel=ROUND_ENC/DEC; round counts 1..9 (enc) or 9..1 (dec); the FSM moves to FINAL after the ninth cycle.
REQ-020 In FINAL (1 cycle): load_en=1; mux_sel=FINAL_ENC/DEC; round=10 (enc) or 0 (dec).
REQ-021 In DONE: out_valid=1, mux_sel=HOLD, load_en=0; out_valid&out_ready moves the FSM to IDLE, so back-to-back blocks are not overlapped.
REQ-022 Latency: if accepted in cycle T, INIT is in T+1, FINAL in T+11, and out_valid is first high in T+12.
REQ-023 rcon SHALL be RCON(round) when encrypting and RCON(round+1) when decrypting, with RCON(1..10)=01,02,04,08,10,20,40,80,1B,36.
REQ-024 rcon SHALL be 00 when the index is 0 or 11, and in IDLE, DONE and CLEAR.
REQ-025 mode SHALL be sampled only at acceptance and held internally until IDLE.
REQ-026 abort in INIT, ROUND, FINAL or DONE SHALL move the FSM to CLEAR.
REQ-027 abort SHALL force out_valid low in the next cycle.
REQ-028 In CLEAR (1 cycle): mux_sel=ZERO, load_en=1, round=0; the FSM then returns to IDLE.
REQ-029 abort together with in_valid in IDLE: abort wins, no acceptance, and the FSM stays in IDLE.
REQ-030 abort together with out_ready in DONE: abort wins and the FSM goes to CLEAR.
REQ-031 All outputs except in_ready SHALL be decoded from registered state only, with no input-to-output combinational path.

Reset
REQ-032 Asserting rst_n low SHALL immediately force IDLE and set out_valid=0, busy=0, load_en=0, mux_sel=HOLD, round=0, rcon=00, in_ready=1.
REQ-033 Reset mid-operation SHALL discard the block and SHALL NOT produce a CLEAR cycle.

Configuration
REQ-034 With AES_DECRYPT_EN defined: mode port present and decrypt sequencing (sels 4-6, descending round) supported.
REQ-035 Without AES_DECRYPT_EN: no mode port, encrypt only, and sels 4-6 are never driven.

Structure
REQ-036 A shared package aes_pkg SHALL hold the mux_sel encodings, the FSM state typedef, NUM_ROUNDS=10 and the RCON table.
REQ-037 A sub-module aes_rcon_lut SHALL map a 4-bit index to the 8-bit RCON value.

Verification
REQ-038 Encrypt: in_valid=1 at T -> mux_sel 0,1x9,2,3 at T+1..T+12; round 0..10; rcon 00,01..36; out_valid at T+12.
REQ-039 Decrypt (AES_DECRYPT_EN): same stimulus -> mux_sel 4,5x9,6,3; round 10,9..1,0; rcon 00,36,1B..01.
REQ-040 abort at ROUND with round=5 -> next cycle CLEAR (mux_sel=7, load_en=1), then IDLE with in_ready=1 and out_valid never high.
REQ-041 DONE with out_ready=0 for 20 cycles -> out_valid held, mux_sel=3, load_en=0; out_ready=1 -> IDLE next cycle.
REQ-042 rst_n low during FINAL -> immediate IDLE with all outputs at reset values, and no CLEAR cycle.
REQ-043 in_valid and abort both 1 in IDLE -> no acceptance, busy stays 0.
